rd_mutex_pipe: RTL and testbench

//  Holds the register/memory/eflags reservation masks of instructions that have left the read stage.

---
 rtl/rd_mutex_pipe_if.sv | 31 +++
 rtl/rd_mutex_pipe.sv | 86 ++++++++
 tb/tb_rd_mutex_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rd_mutex_pipe_if.sv
// Handshake and mask bundle between the read-stage mutex logic and the
// exe/wr reservation pipe.
interface rd_mutex_pipe_if #(
  parameter int unsigned MUTEX_W = 11,
  parameter int unsigned CNT_W   = 16
);
  logic               pipeline_flush;
  logic [MUTEX_W-1:0] rd_mutex_next;
  logic               rd_accepted;
  logic               exe_accepted;
  logic               wr_finished;
  logic               rd_stalled;
  logic               perf_clear;
  logic [MUTEX_W-1:0] exe_mutex;
  logic [MUTEX_W-1:0] wr_mutex;
  logic [MUTEX_W-1:0] mutex_current;
  logic [CNT_W-1:0]   stall_cycles;
  logic               protocol_error;

  modport master (
    output pipeline_flush, rd_mutex_next, rd_accepted, exe_accepted, wr_finished,
           rd_stalled, perf_clear,
    input  exe_mutex, wr_mutex, mutex_current, stall_cycles, protocol_error
  );

  modport slave (
    input  pipeline_flush, rd_mutex_next, rd_accepted, exe_accepted, wr_finished,
           rd_stalled, perf_clear,
    output exe_mutex, wr_mutex, mutex_current, stall_cycles, protocol_error
  );
endinterface

// File: rtl/rd_mutex_pipe.sv
// Execute/write reservation slots for instructions past the read stage, with a
// saturating read-stall counter and a sticky handshake-error flag.
module rd_mutex_pipe #(
  parameter int unsigned MUTEX_W = 11,
  parameter int unsigned CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  rd_mutex_pipe_if.slave bus
);

  localparam int unsigned Act = MUTEX_W - 1;

  logic [MUTEX_W-1:0] exe_q, exe_d;
  logic [MUTEX_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               exe_occ, wr_occ, bad_hs;
  logic [MUTEX_W-1:0] cur;

  assign exe_occ = exe_q[Act];
  assign wr_occ  = wr_q[Act];
  assign cur     = exe_q | wr_q;

  always_comb begin
    exe_d = exe_q;
    if (bus.pipeline_flush) begin
      exe_d = '0;
    end else if (bus.rd_accepted) begin
      exe_d      = bus.rd_mutex_next;
      exe_d[Act] = 1'b1;
    end else if (bus.exe_accepted) begin
      exe_d = '0;
    end
  end

  // exe_q is the pre-load value, so a same-cycle rd load never leaks into wr.
  always_comb begin
    wr_d = wr_q;
    if (bus.pipeline_flush) begin
      wr_d = '0;
    end else if (bus.exe_accepted) begin
      wr_d = exe_q;
    end else if (bus.wr_finished) begin
      wr_d = '0;
    end
  end

  always_comb begin
    bad_hs = (bus.rd_accepted && exe_occ && !bus.exe_accepted) ||
             (bus.exe_accepted && !exe_occ) ||
             (bus.exe_accepted && wr_occ && !bus.wr_finished) ||
             (bus.wr_finished && !wr_occ);
    err_d  = err_q || (bad_hs && !bus.pipeline_flush);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.perf_clear) begin
      cnt_d = '0;
    end else if (bus.rd_stalled && cur[Act] && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      exe_q <= exe_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.exe_mutex      = exe_q;
  assign bus.wr_mutex       = wr_q;
  assign bus.mutex_current  = cur;
  assign bus.stall_cycles   = cnt_q;
  assign bus.protocol_error = err_q;

endmodule

// File: tb/tb_rd_mutex_pipe.sv
// Table-driven bench for rd_mutex_pipe: expected records are queued when a
// vector is driven and popped when the DUT outputs are sampled after the edge.
module tb_rd_mutex_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rd_mutex_pipe_if #(.MUTEX_W(11), .CNT_W(16)) bus ();

  rd_mutex_pipe #(.MUTEX_W(11), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        fl, ra, ea, wf, st, pc;
    logic [10:0] nx;
    logic [10:0] exe, wr;
    logic        err;
    logic [15:0] stall;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[13];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic fl, logic ra, logic [10:0] nx, logic ea, logic wf,
                              logic st, logic pc, logic [10:0] exe, logic [10:0] wr,
                              logic err, logic [15:0] stall);
    vec_t v;
    v.fl = fl; v.ra = ra; v.nx = nx; v.ea = ea; v.wf = wf; v.st = st; v.pc = pc;
    v.exe = exe; v.wr = wr; v.err = err; v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic idle_inputs();
    bus.pipeline_flush = 1'b0;
    bus.rd_mutex_next  = '0;
    bus.rd_accepted    = 1'b0;
    bus.exe_accepted   = 1'b0;
    bus.wr_finished    = 1'b0;
    bus.rd_stalled     = 1'b0;
    bus.perf_clear     = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    bus.pipeline_flush = v.fl;
    bus.rd_accepted    = v.ra;
    bus.rd_mutex_next  = v.nx;
    bus.exe_accepted   = v.ea;
    bus.wr_finished    = v.wf;
    bus.rd_stalled     = v.st;
    bus.perf_clear     = v.pc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got nothing expected a record", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".exe"}, 32'(bus.exe_mutex), 32'(e.exe));
      chk({name, ".wr"}, 32'(bus.wr_mutex), 32'(e.wr));
      chk({name, ".cur"}, 32'(bus.mutex_current), 32'(e.exe | e.wr));
      chk({name, ".err"}, 32'(bus.protocol_error), 32'(e.err));
      chk({name, ".stall"}, 32'(bus.stall_cycles), 32'(e.stall));
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    //               fl  ra  nx      ea  wf  st  pc  exe     wr      err stall
    tbl[0]  = mk(0, 1, 11'h201, 0, 0, 0, 0, 11'h601, 11'h000, 0, 16'd0);
    tbl[1]  = mk(0, 1, 11'h104, 1, 0, 0, 0, 11'h504, 11'h601, 0, 16'd0);
    tbl[2]  = mk(0, 0, 11'h000, 0, 0, 1, 0, 11'h504, 11'h601, 0, 16'd1);
    tbl[3]  = mk(0, 0, 11'h000, 1, 1, 0, 0, 11'h000, 11'h504, 0, 16'd1);
    tbl[4]  = mk(0, 0, 11'h000, 0, 1, 0, 0, 11'h000, 11'h000, 0, 16'd1);
    tbl[5]  = mk(0, 0, 11'h000, 0, 0, 1, 0, 11'h000, 11'h000, 0, 16'd1);
    tbl[6]  = mk(0, 1, 11'h0FF, 0, 0, 0, 0, 11'h4FF, 11'h000, 0, 16'd1);
    tbl[7]  = mk(0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 11'h4FF, 0, 16'd1);
    tbl[8]  = mk(0, 1, 11'h00A, 0, 0, 0, 0, 11'h40A, 11'h4FF, 0, 16'd1);
    tbl[9]  = mk(1, 1, 11'h3FF, 1, 1, 1, 0, 11'h000, 11'h000, 0, 16'd2);
    tbl[10] = mk(0, 1, 11'h001, 0, 0, 1, 1, 11'h401, 11'h000, 0, 16'd0);
    tbl[11] = mk(0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 11'h401, 0, 16'd0);
    tbl[12] = mk(0, 0, 11'h000, 0, 1, 0, 0, 11'h000, 11'h000, 0, 16'd0);

    do_reset();
    chk("reset.exe", 32'(bus.exe_mutex), 32'h0);
    chk("reset.wr", 32'(bus.wr_mutex), 32'h0);
    chk("reset.cur", 32'(bus.mutex_current), 32'h0);
    chk("reset.stall", 32'(bus.stall_cycles), 32'h0);
    chk("reset.err", 32'(bus.protocol_error), 32'h0);

    for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Masks must not follow handshakes combinationally.
    do_reset();
    bus.rd_accepted   = 1'b1;
    bus.rd_mutex_next = 11'h123;
    #1;
    chk("no_comb_path", 32'(bus.exe_mutex), 32'h0);
    apply(mk(0, 1, 11'h123, 0, 0, 0, 0, 11'h523, 11'h000, 0, 16'd0), "load123");

    // Async reset in the middle of a cycle clears the slot before the next edge.
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.exe", 32'(bus.exe_mutex), 32'h0);
    rst = 1'b0;
    exp_q.delete();

    // wr_finished with wr empty: sticky until reset.
    do_reset();
    apply(mk(0, 0, 11'h000, 0, 1, 0, 0, 11'h000, 11'h000, 1, 16'd0), "err_wf");
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 11'h000, 0, 0, 0, 0, 11'h000, 11'h000, 1, 16'd0), "err_sticky");
    do_reset();
    chk("err_cleared", 32'(bus.protocol_error), 32'h0);

    // exe_accepted with exe empty.
    apply(mk(0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 11'h000, 1, 16'd0), "err_ea_empty");

    // rd_accepted into an occupied exe slot without exe_accepted.
    do_reset();
    apply(mk(0, 1, 11'h001, 0, 0, 0, 0, 11'h401, 11'h000, 0, 16'd0), "ov_ld1");
    apply(mk(0, 1, 11'h002, 0, 0, 0, 0, 11'h402, 11'h000, 1, 16'd0), "ov_ld2");

    // exe_accepted into an occupied wr slot without wr_finished.
    do_reset();
    apply(mk(0, 1, 11'h001, 0, 0, 0, 0, 11'h401, 11'h000, 0, 16'd0), "wo_a");
    apply(mk(0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 11'h401, 0, 16'd0), "wo_b");
    apply(mk(0, 1, 11'h002, 0, 0, 0, 0, 11'h402, 11'h401, 0, 16'd0), "wo_c");
    apply(mk(0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 11'h402, 1, 16'd0), "wo_d");

    // Stall counter saturation.
    do_reset();
    apply(mk(0, 1, 11'h000, 0, 0, 0, 0, 11'h400, 11'h000, 0, 16'd0), "sat_load");
    idle_inputs();
    bus.rd_stalled = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    apply(mk(0, 0, 11'h000, 0, 0, 1, 0, 11'h400, 11'h000, 0, 16'hFFFF), "sat_reach");
    repeat (4465) @(posedge clk);
    #1;
    apply(mk(0, 0, 11'h000, 0, 0, 1, 0, 11'h400, 11'h000, 0, 16'hFFFF), "sat_hold");
    apply(mk(0, 0, 11'h000, 0, 0, 1, 1, 11'h400, 11'h000, 0, 16'h0000), "sat_clear");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
